// File: rtl/router_fsm.sv
// router_fsm: control FSM for the 1x3 router.
// Decodes the destination from the header byte, sequences the packet
// register stage and generates the destination FIFO write enable.
// Optional feature macro: STALL_TIMEOUT_EN (abort a WAIT_TILL_EMPTY stall
// after TIMEOUT_CYCLES cycles and pulse timeout_err).
//
// state              | meaning
// -------------------+---------------------------------------------------
// DECODE_ADDRESS     | idle, sampling header byte for destination address
// LOAD_FIRST_DATA    | header accepted, register stage loads first byte
// LOAD_DATA          | payload bytes written to the destination FIFO
// FIFO_FULL_STATE    | destination FIFO full, input held
// LOAD_AFTER_FULL    | write the byte held during the full stall
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | register stage compares parity, internal reset
// WAIT_TILL_EMPTY    | destination FIFO still draining previous packet
module router_fsm #(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int TO_W           = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] soft_reset,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [1:0] dest_addr,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   empty_din;
    logic   empty_dest;
    logic   soft_dest;
    logic   hdr_ok;
    logic   abort;

    // Per-FIFO flag lookups; address 3 selects no FIFO.
    always_comb begin
        empty_din  = 1'b0;
        empty_dest = 1'b0;
        soft_dest  = 1'b0;
        case (data_in)
            2'd0:    empty_din = fifo_empty[0];
            2'd1:    empty_din = fifo_empty[1];
            2'd2:    empty_din = fifo_empty[2];
            default: empty_din = 1'b0;
        endcase
        case (dest_addr)
            2'd0: begin
                empty_dest = fifo_empty[0];
                soft_dest  = soft_reset[0];
            end
            2'd1: begin
                empty_dest = fifo_empty[1];
                soft_dest  = soft_reset[1];
            end
            2'd2: begin
                empty_dest = fifo_empty[2];
                soft_dest  = soft_reset[2];
            end
            default: begin
                empty_dest = 1'b0;
                soft_dest  = 1'b0;
            end
        endcase
    end

    assign hdr_ok = pkt_valid && (data_in != 2'd3);

`ifdef STALL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Empty flag and soft reset both take precedence over the abort.
    assign abort = (state == WAIT_TILL_EMPTY) && !empty_dest && !soft_dest &&
                   (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Stall counter runs only in WAIT_TILL_EMPTY; error pulse follows the abort edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= (state == WAIT_TILL_EMPTY) ? to_cnt + 1'b1 : '0;
            timeout_err <= abort;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register and destination address latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= DECODE_ADDRESS;
            dest_addr <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && hdr_ok)
                dest_addr <= data_in;
        end
    end

    // Next-state logic: soft reset, then timeout abort, then normal sequencing.
    always_comb begin
        state_nxt = state;
        if (state != DECODE_ADDRESS && soft_dest) begin
            state_nxt = DECODE_ADDRESS;
        end else if (abort) begin
            state_nxt = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS:
                    if (hdr_ok)
                        state_nxt = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:
                    state_nxt = LOAD_DATA;
                LOAD_DATA:
                    if (fifo_full)
                        state_nxt = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        state_nxt = LOAD_PARITY;
                FIFO_FULL_STATE:
                    if (!fifo_full)
                        state_nxt = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (parity_done)
                        state_nxt = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        state_nxt = LOAD_PARITY;
                    else
                        state_nxt = LOAD_DATA;
                LOAD_PARITY:
                    state_nxt = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:
                    if (empty_dest)
                        state_nxt = LOAD_FIRST_DATA;
                default:
                    state_nxt = DECODE_ADDRESS;
            endcase
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed self-checking bench for router_fsm.
// Follows STALL_TIMEOUT_EN the same way the design does.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy, timeout_err;
    logic [1:0] dest_addr;
    logic [7:0] obs;

    int errors = 0;
    int checks = 0;

    localparam int DA = 0, LFD = 1, LD = 2, FFS = 3, LAF = 4, LP = 5, CPE = 6, WTE = 7;

    router_fsm #(.TIMEOUT_CYCLES(30), .TO_W(5)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .dest_addr(dest_addr),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, write_enb_reg, busy};

    function automatic logic [7:0] exp_outs(input int st);
        case (st)
            DA:      return 8'b1000_0000;
            LFD:     return 8'b0100_0001;
            LD:      return 8'b0010_0010;
            FFS:     return 8'b0000_1001;
            LAF:     return 8'b0001_0011;
            LP:      return 8'b0000_0011;
            CPE:     return 8'b0000_0101;
            default: return 8'b0000_0001;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pkt_valid = 0; data_in = 0; fifo_full = 0; fifo_empty = 3'b111;
        soft_reset = 0; parity_done = 0; low_pkt_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        cyc(); cyc();
        reset = 0;
        checks++;
        if (obs !== exp_outs(DA) || dest_addr !== 2'd0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got outs=%b dest=%0d terr=%b, expected outs=%b dest=0 terr=0",
                     obs, dest_addr, timeout_err, exp_outs(DA));
        end
    endtask

    task automatic test_packet();
        int pv_v [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int ex_v [8] = '{LFD, LD, LD, LD, LD, LP, CPE, DA};
        int we_n = 0;
        int ri_n = 0;
        idle();
        data_in = 2'd1;
        for (int i = 0; i < 8; i++) begin
            pkt_valid = pv_v[i][0];
            cyc();
            data_in = 2'd0;
            if (write_enb_reg) we_n++;
            if (rst_int_reg) ri_n++;
            checks++;
            if (obs !== exp_outs(ex_v[i])) begin
                errors++;
                $display("FAIL packet_step%0d: got outs=%b expected %b", i, obs, exp_outs(ex_v[i]));
            end
        end
        checks++;
        if (we_n != 5 || ri_n != 1 || dest_addr !== 2'd1) begin
            errors++;
            $display("FAIL packet_totals: got we=%0d rst_int=%0d dest=%0d, expected 5 1 1",
                     we_n, ri_n, dest_addr);
        end
    endtask

    task automatic test_full_stall();
        int pv_v [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int fu_v [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        int ex_v [10] = '{LFD, LD, FFS, FFS, FFS, LAF, LD, LP, CPE, DA};
        idle();
        data_in = 2'd1;
        for (int i = 0; i < 10; i++) begin
            pkt_valid = pv_v[i][0];
            fifo_full = fu_v[i][0];
            cyc();
            data_in = 2'd0;
            checks++;
            if (obs !== exp_outs(ex_v[i])) begin
                errors++;
                $display("FAIL full_stall_step%0d: got outs=%b expected %b", i, obs, exp_outs(ex_v[i]));
            end
        end
    endtask

    task automatic test_bad_addr();
        idle();
        pkt_valid = 1; data_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (obs !== exp_outs(DA)) begin
                errors++;
                $display("FAIL bad_addr_step%0d: got outs=%b expected %b", i, obs, exp_outs(DA));
            end
        end
        checks++;
        if (dest_addr !== 2'd1) begin
            errors++;
            $display("FAIL bad_addr_dest: got %0d expected 1", dest_addr);
        end
        idle();
    endtask

    task automatic test_wait_empty();
        int n = 0;
        idle();
        pkt_valid = 1; data_in = 2'd2; fifo_empty = 3'b011;
        cyc();
        pkt_valid = 0; data_in = 2'd0;
        for (int i = 0; i < 10; i++) begin
            if (obs === exp_outs(WTE)) n++;
            if (i < 9) cyc();
        end
        checks++;
        if (n != 10 || dest_addr !== 2'd2) begin
            errors++;
            $display("FAIL wait_empty_len: got %0d WTE cycles dest=%0d, expected 10 dest=2", n, dest_addr);
        end
        fifo_empty = 3'b111;
        cyc();
        checks++;
        if (obs !== exp_outs(LFD)) begin
            errors++;
            $display("FAIL wait_empty_exit: got outs=%b expected %b", obs, exp_outs(LFD));
        end
        soft_reset = 3'b001;
        cyc();
        checks++;
        if (obs !== exp_outs(LD)) begin
            errors++;
            $display("FAIL soft_other_ld: got outs=%b expected %b", obs, exp_outs(LD));
        end
        soft_reset = 3'b100; pkt_valid = 1;
        cyc();
        soft_reset = 3'b000; pkt_valid = 0;
        checks++;
        if (obs !== exp_outs(DA)) begin
            errors++;
            $display("FAIL soft_own_ld: got outs=%b expected %b", obs, exp_outs(DA));
        end
        pkt_valid = 1; data_in = 2'd2; fifo_empty = 3'b011;
        cyc();
        pkt_valid = 0; data_in = 2'd0;
        soft_reset = 3'b001;
        cyc();
        checks++;
        if (obs !== exp_outs(WTE)) begin
            errors++;
            $display("FAIL soft_other_wte: got outs=%b expected %b", obs, exp_outs(WTE));
        end
        soft_reset = 3'b100;
        cyc();
        soft_reset = 3'b000;
        checks++;
        if (obs !== exp_outs(DA)) begin
            errors++;
            $display("FAIL soft_own_wte: got outs=%b expected %b", obs, exp_outs(DA));
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        pkt_valid = 1; data_in = 2'd2;
        cyc(); cyc();
        checks++;
        if (obs !== exp_outs(LD)) begin
            errors++;
            $display("FAIL reset_mid_pre: got outs=%b expected %b", obs, exp_outs(LD));
        end
        reset = 1;
        cyc();
        reset = 0; pkt_valid = 0; data_in = 2'd0;
        checks++;
        if (obs !== exp_outs(DA) || dest_addr !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: got outs=%b dest=%0d, expected %b dest=0",
                     obs, dest_addr, exp_outs(DA));
        end
    endtask

    task automatic test_boundaries();
        idle();
        pkt_valid = 1; data_in = 2'd0;
        cyc(); cyc();
        pkt_valid = 0; fifo_full = 1;
        cyc();
        checks++;
        if (obs !== exp_outs(FFS)) begin
            errors++;
            $display("FAIL full_wins: got outs=%b expected %b", obs, exp_outs(FFS));
        end
        fifo_full = 0;
        cyc();
        parity_done = 1;
        cyc();
        parity_done = 0;
        checks++;
        if (obs !== exp_outs(DA)) begin
            errors++;
            $display("FAIL laf_parity_done: got outs=%b expected %b", obs, exp_outs(DA));
        end
        pkt_valid = 1;
        cyc(); cyc();
        fifo_full = 1;
        cyc();
        fifo_full = 0;
        cyc();
        low_pkt_valid = 1;
        cyc();
        low_pkt_valid = 0; pkt_valid = 0;
        checks++;
        if (obs !== exp_outs(LP)) begin
            errors++;
            $display("FAIL laf_low_pkt: got outs=%b expected %b", obs, exp_outs(LP));
        end
        cyc();
        fifo_full = 1;
        cyc();
        fifo_full = 0;
        checks++;
        if (obs !== exp_outs(FFS)) begin
            errors++;
            $display("FAIL cpe_full: got outs=%b expected %b", obs, exp_outs(FFS));
        end
        cyc();
        parity_done = 1;
        cyc();
        parity_done = 0;
        pkt_valid = 1; data_in = 2'd1;
        cyc();
        data_in = 2'd0;
        cyc();
        pkt_valid = 0;
        cyc(); cyc();
        checks++;
        if (obs !== exp_outs(CPE)) begin
            errors++;
            $display("FAIL b2b_cpe: got outs=%b expected %b", obs, exp_outs(CPE));
        end
        cyc();
        pkt_valid = 1; data_in = 2'd2;
        cyc();
        pkt_valid = 0; data_in = 2'd0;
        checks++;
        if (obs !== exp_outs(LFD) || dest_addr !== 2'd2) begin
            errors++;
            $display("FAIL back_to_back: got outs=%b dest=%0d, expected %b dest=2",
                     obs, dest_addr, exp_outs(LFD));
        end
        cyc(); cyc(); cyc(); cyc();
        idle();
    endtask

    task automatic test_timeout();
        int n = 0;
        int bad = 0;
        idle();
        cyc();
        pkt_valid = 1; data_in = 2'd1; fifo_empty = 3'b101;
        cyc();
        pkt_valid = 0; data_in = 2'd0;
`ifdef STALL_TIMEOUT_EN
        while (obs === exp_outs(WTE) && n < 40) begin
            if (timeout_err !== 1'b0) bad++;
            n++;
            cyc();
        end
        checks++;
        if (n != 30 || bad != 0) begin
            errors++;
            $display("FAIL timeout_len: got %0d WTE cycles (%0d early errs), expected 30 and 0", n, bad);
        end
        checks++;
        if (obs !== exp_outs(DA) || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: got outs=%b terr=%b, expected %b terr=1",
                     obs, timeout_err, exp_outs(DA));
        end
        cyc();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_width: got terr=%b expected 0", timeout_err);
        end
        pkt_valid = 1; data_in = 2'd1;
        cyc();
        pkt_valid = 0; data_in = 2'd0;
        for (int i = 0; i < 29; i++) cyc();
        fifo_empty = 3'b111;
        cyc();
        checks++;
        if (obs !== exp_outs(LFD) || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_empty_wins: got outs=%b terr=%b, expected %b terr=0",
                     obs, timeout_err, exp_outs(LFD));
        end
        soft_reset = 3'b010;
        cyc();
        soft_reset = 3'b000;
`else
        for (int i = 0; i < 40; i++) begin
            if (obs === exp_outs(WTE) && timeout_err === 1'b0) n++;
            cyc();
        end
        checks++;
        if (n != 40) begin
            errors++;
            $display("FAIL no_timeout: got %0d good WTE cycles, expected 40", n);
        end
        soft_reset = 3'b010;
        cyc();
        soft_reset = 3'b000;
`endif
        checks++;
        if (obs !== exp_outs(DA)) begin
            errors++;
            $display("FAIL timeout_exit: got outs=%b expected %b", obs, exp_outs(DA));
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_packet();
        test_full_stall();
        test_bad_addr();
        test_wait_empty();
        test_reset_mid();
        test_boundaries();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1x3 router.
- Decodes the destination address from the header byte and sequences the packet register stage through its phases: header load, payload load, stall on full, parity load and parity check.
- Generates the load/state strobes consumed by the register stage and the write enable for the destination FIFO.
- Sits between the input port and the register stage/synchroniser; all state outputs are Moore-decoded.

Parameters:
- TIMEOUT_CYCLES, 30, cycles allowed in WAIT_TILL_EMPTY before abort (used only with STALL_TIMEOUT_EN).
- TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  high while header/payload bytes are on the input bus; low on the parity byte.
- data_in  in  2  bits [1:0] of the input byte; destination address (3 = invalid).
- fifo_full  in  1  full flag of the currently addressed FIFO.
- fifo_empty  in  3  empty flags of FIFO 0..2.
- soft_reset  in  3  per-FIFO soft-reset (read timeout) pulses.
- parity_done  in  1  from register stage.
- low_pkt_valid  in  1  from register stage.
- detect_add  out  1  high in DECODE_ADDRESS.
- lfd_state  out  1  high in LOAD_FIRST_DATA.
- ld_state  out  1  high in LOAD_DATA.
- laf_state  out  1  high in LOAD_AFTER_FULL.
- full_state  out  1  high in FIFO_FULL_STATE.
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  out  1  FIFO write enable.
- busy  out  1  input must hold the current byte.
- dest_addr  out  2  latched destination address.
- timeout_err  out  1  one-cycle abort pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state = DECODE_ADDRESS, dest_addr = 0, timeout counter = 0.
  - Outputs after reset: detect_add = 1; all other strobes = 0; write_enb_reg = 0; busy = 0; timeout_err = 0.
- Address latch: in DECODE_ADDRESS, when pkt_valid = 1 and data_in != 3, dest_addr <= data_in on that edge.
- Address-qualified signals: all empty/soft_reset lookups outside DECODE_ADDRESS use the latched dest_addr. Lookups inside DECODE_ADDRESS use data_in.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid and addr != 3 and fifo_empty[addr] -> LOAD_FIRST_DATA.
    - pkt_valid and addr != 3 and !fifo_empty[addr] -> WAIT_TILL_EMPTY.
    - otherwise stay. An addr = 3 header is ignored: no write, no busy.
  - LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE.
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA, else stay.
- Priority (highest first): reset; then soft_reset[dest_addr] in any state other than DECODE_ADDRESS (-> DECODE_ADDRESS next edge); then timeout abort; then the table above.
  - soft_reset for a non-addressed FIFO has no effect.
- Output decode (from state register only, no input dependence):
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = every state except DECODE_ADDRESS and LOAD_DATA.
- Latency:
  - Header accepted -> lfd_state high the next cycle.
  - First payload write at the second cycle after the header.
- Boundary cases:
  - fifo_full and !pkt_valid together in LOAD_DATA -> FIFO_FULL_STATE (full wins).
  - Back-to-back packets: a new header is sampled in the DECODE_ADDRESS cycle immediately following CHECK_PARITY_ERROR.

Optional Feature:
- Macro: STALL_TIMEOUT_EN.
- Defined:
  - Counter clears on every entry to WAIT_TILL_EMPTY and increments each cycle spent there.
  - When the count reaches TIMEOUT_CYCLES-1 while still not empty, next state = DECODE_ADDRESS and timeout_err pulses high for exactly one cycle, coincident with the transition edge.
  - An empty flag arriving on the same cycle as the timeout wins: go to LOAD_FIRST_DATA, no error pulse.
- Not defined: WAIT_TILL_EMPTY waits indefinitely; timeout_err tied to 0; no counter logic.

Test Plan:
- Reset mid-LOAD_DATA: assert reset one cycle -> next cycle detect_add = 1, busy = 0, write_enb_reg = 0, dest_addr = 0.
- Header 0x05 (addr 1), fifo_empty = 3'b111, pkt_valid high 4 payload bytes then low -> state sequence DA, LFD, LD x4, LP, CPE, DA. write_enb_reg high 5 cycles; rst_int_reg high 1 cycle; dest_addr = 1.
- Same packet, fifo_full high 3 cycles on the 2nd payload byte -> LD, FFS x3, LAF, LD. busy high during FFS and LAF; no write during FFS.
- Header addr 3 with pkt_valid -> FSM stays in DA; write_enb_reg = 0, busy = 0 throughout.
- Header addr 2, fifo_empty[2] = 0 for 10 cycles then 1 -> WTE for 10 cycles then LFD. A soft_reset[2] pulse during WTE in a rerun -> DA next cycle; a soft_reset[0] pulse -> no effect.
- STALL_TIMEOUT_EN defined, TIMEOUT_CYCLES = 30, fifo_empty[1] held 0 -> exactly 30 cycles in WTE, then DA with timeout_err high for 1 cycle. Macro undefined -> stays in WTE, timeout_err = 0.
